pool_lin_drain: RTL
===================

Name: pool_lin_drain

Overview:
- Reader for the pooled line registers that the three-channel pool stage writes (pool_lin_D1..D3, 3 bytes per channel).
- On each line-complete strobe, snapshots all 9 pooled bytes into a 2-entry ping-pong buffer.
- Streams the bytes one per handshake to the linear (FC) layer, tagged with channel, column, row and end-of-frame.
- Decouples pool timing from FC consumption; drops and flags a line when both buffers are occupied.

Parameters:
- ROWS, 3, pooled rows per frame. Row tag wraps after ROWS-1.
- DW, 8, byte width of one pooled value. pool_lin ports are 3*DW.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- line_done  in  1  one-cycle strobe: pool_lin_D1..D3 hold a complete pooled row this cycle
- pool_lin_D1  in  3*DW  channel 1 row; bits [DW-1:0] = column 0, next DW = column 1, top DW = column 2
- pool_lin_D2  in  3*DW  channel 2 row, same packing
- pool_lin_D3  in  3*DW  channel 3 row, same packing
- out_vld  out  1  out_data valid
- out_rdy  in  1  consumer ready; transfer occurs when out_vld && out_rdy
- out_data  out  DW  pooled byte
- out_ch  out  2  channel of out_data: 0 = D1, 1 = D2, 2 = D3
- out_col  out  2  column 0..2
- out_row  out  $clog2(ROWS)  row tag of the buffered line
- out_last  out  1  high on the final byte (ch 2, col 2) of row ROWS-1
- ovf  out  1  sticky overflow: a line was dropped; cleared only by reset
- busy  out  1  at least one buffer entry occupied

Behaviour:
- Reset (async, rst_n low) values:
  - wptr = 0, rptr = 0, count = 0, byte index = 0, row counter = 0.
  - out_vld = 0, out_data = 0, out_ch = 0, out_col = 0, out_row = 0, out_last = 0, ovf = 0, busy = 0.
  - Buffer contents are don't-care.
  - Reset mid-stream discards both entries; no partial line is ever resumed.
- Buffer: 2 entries. Each entry holds 9 bytes plus its row tag. State is wptr, rptr, count (0..2).
- pop = out_vld && out_rdy && byte index == 8.
- Capture:
  - line_done is accepted when count < 2, or when count == 2 and pop occurs in the same cycle.
  - On accept at edge N:
    - buf[wptr] <= {D1, D2, D3}; entry row tag <= row counter.
    - wptr toggles.
    - Row counter increments, wrapping ROWS-1 -> 0.
  - Not accepted (count == 2, no pop): the line is dropped. ovf <= 1. Row counter is unchanged.
- count update per cycle: +1 on accepted capture, -1 on pop, unchanged when both occur.
- Streaming:
  - out_vld = (count != 0), from registers, with no combinational path from line_done.
  - First byte is visible the cycle after the capturing edge (latency 1).
  - Byte order is channel-major: (ch0 col0..2), (ch1 col0..2), (ch2 col0..2). Byte index runs 0..8; ch = idx/3, col = idx%3.
  - out_data/out_ch/out_col/out_row are driven from buf[rptr] and the byte index.
  - Each transfer advances the byte index. At index 8 a transfer pops the entry: index <= 0, rptr toggles.
  - While out_vld && !out_rdy, all outputs hold stable. A capture never writes buf[rptr] unless that entry pops at the same edge.
- out_last = out_vld && idx == 8 && entry row tag == ROWS-1.
- busy = (count != 0).
- line_done while count == 0 and out_rdy held high: 9 transfers in 9 consecutive cycles. Entries stream back-to-back with no bubble.
- Arithmetic: counters wrap modulo their range. No saturation except ovf, which is sticky.

Test Plan:
- Single line: D1=0x030201, D2=0x060504, D3=0x090807, one line_done, out_rdy=1 -> out_vld rises the next cycle. Bytes 01..09 over 9 cycles, ch/col sequencing 0/0..2/2, out_row=0, out_last=0, then out_vld=0.
- Backpressure: same line, out_rdy toggling 1,0,0,1,... -> no byte lost or repeated. out_data held while stalled. Exactly 9 transfers.
- Frame tag: 3 lines (ROWS=3) with out_rdy=1 -> out_row 0,1,2. out_last high only on the 27th transfer, value = line-2 D3[23:16]. Row wraps to 0 on the 4th line.
- Overflow: out_rdy=0, three line_done strobes with distinct data -> count=2, third line dropped, ovf=1. Then out_rdy=1 -> exactly 18 bytes from lines 1 and 2. ovf stays 1.
- Simultaneous: count=2, line_done coincident with the final-byte transfer of entry 0 -> new line accepted, ovf stays 0. Output streams entry 1 then the new line.
- Async reset mid-stream: assert rst_n low after 4 transfers -> all outputs 0 immediately. After release, a new line streams from byte 0 with out_row=0.

Source files
------------

// File: rtl/pool_lin_drain_if.sv
// Byte stream from the pooled-line drain to the linear layer.
// The master drives the tagged byte and its valid flag; the slave drives ready.
interface pool_lin_drain_if #(
  parameter int DW = 8,
  parameter int RW = 2
);
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic [1:0]    out_ch;
  logic [1:0]    out_col;
  logic [RW-1:0] out_row;
  logic          out_last;

  modport master (
    output out_vld, out_data, out_ch, out_col, out_row, out_last,
    input  out_rdy
  );

  modport slave (
    input  out_vld, out_data, out_ch, out_col, out_row, out_last,
    output out_rdy
  );
endinterface

// File: rtl/pool_lin_drain.sv
// Snapshots each completed 3x3 pooled row into a 2-entry ping-pong buffer and
// streams it byte by byte, channel-major, with ch/col/row/last tags.
module pool_lin_drain #(
  parameter int ROWS = 3,
  parameter int DW   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                line_done,
  input  logic [3*DW-1:0]     pool_lin_D1,
  input  logic [3*DW-1:0]     pool_lin_D2,
  input  logic [3*DW-1:0]     pool_lin_D3,
  pool_lin_drain_if.master    strm,
  output logic                ovf,
  output logic                busy
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [9*DW-1:0] ent_dat [2];
  logic [RW-1:0]   ent_row [2];
  logic            wptr;
  logic            rptr;
  logic [1:0]      count;
  logic [3:0]      idx;
  logic [RW-1:0]   row_cnt;

  logic            vld;
  logic            xfer;
  logic            pop;
  logic            accept;
  logic [9*DW-1:0] cur;
  logic [DW-1:0]   sel_byte;
  logic [1:0]      ch;
  logic [1:0]      col;
  logic [3:0]      ch_base;

  assign vld    = (count != 2'd0);
  assign xfer   = vld && strm.out_rdy;
  assign pop    = xfer && (idx == 4'd8);
  // With both entries full, wptr == rptr, so a capture is only safe if that entry leaves now.
  assign accept = line_done && ((count != 2'd2) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      count   <= 2'd0;
      idx     <= 4'd0;
      row_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      if (accept) begin
        wptr    <= ~wptr;
        row_cnt <= (row_cnt == RW'(ROWS - 1)) ? '0 : row_cnt + 1'b1;
      end else if (line_done) begin
        ovf <= 1'b1;
      end

      if (pop) begin
        idx  <= 4'd0;
        rptr <= ~rptr;
      end else if (xfer) begin
        idx <= idx + 4'd1;
      end

      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset: contents are meaningless until captured.
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_dat[wptr] <= {pool_lin_D3, pool_lin_D2, pool_lin_D1};
      ent_row[wptr] <= row_cnt;
    end
  end

  always_comb begin
    ch      = 2'd0;
    ch_base = 4'd0;
    if (idx >= 4'd6) begin
      ch      = 2'd2;
      ch_base = 4'd6;
    end else if (idx >= 4'd3) begin
      ch      = 2'd1;
      ch_base = 4'd3;
    end
    col      = 2'(idx - ch_base);
    cur      = ent_dat[rptr];
    sel_byte = cur[idx*DW +: DW];
  end

  always_comb begin
    strm.out_vld  = vld;
    strm.out_data = vld ? sel_byte : '0;
    strm.out_ch   = vld ? ch : 2'd0;
    strm.out_col  = vld ? col : 2'd0;
    strm.out_row  = vld ? ent_row[rptr] : '0;
    strm.out_last = vld && (idx == 4'd8) && (ent_row[rptr] == RW'(ROWS - 1));
  end

  assign busy = vld;

endmodule
